// File: rtl/cart_pkg.sv
// Shared constants, state encoding and title lookup for the emulated
// Game Boy Camera cartridge header.
package cart_pkg;

   localparam logic [15:0] HEADER_BASE = 16'h0100;
   localparam logic [15:0] HEADER_LAST = 16'h014F;

   localparam logic [15:0] TITLE_BASE = 16'h0134;
   localparam int          TITLE_LEN  = 13;

   localparam logic [15:0] CSUM_FIRST = 16'h0134;
   localparam logic [15:0] CSUM_LAST  = 16'h014C;
   localparam logic [15:0] CSUM_ADDR  = 16'h014D;
   localparam int          CSUM_COUNT = int'(CSUM_LAST - CSUM_FIRST) + 1;

   localparam logic [15:0] CART_TYPE_ADDR = 16'h0147;
   localparam logic [15:0] ROM_SIZE_ADDR  = 16'h0148;
   localparam logic [15:0] RAM_SIZE_ADDR  = 16'h0149;
   localparam logic [15:0] LICENSEE_ADDR  = 16'h014B;
   localparam logic [15:0] FAULT_ADDR     = 16'h013A;

   localparam logic [7:0] CART_TYPE_CAMERA = 8'hFC;
   localparam logic [7:0] ROM_SIZE_VALUE   = 8'h05;
   localparam logic [7:0] RAM_SIZE_VALUE   = 8'h04;
   localparam logic [7:0] LICENSEE_VALUE   = 8'h01;

   localparam logic [8*TITLE_LEN-1:0] TITLE_STR = "GAMEBOYCAMERA";

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      IDLE  = 2'd1,
      WAIT  = 2'd2,
      VALID = 2'd3
   } cart_state_t;

   // The string literal packs its first character in the top byte.
   function automatic logic [7:0] title_byte(input logic [3:0] pos);
      return TITLE_STR[8*(TITLE_LEN-1-int'(pos)) +: 8];
   endfunction

endpackage

// File: rtl/cart_header_rom.sv
// Combinational image of the cartridge header (0x0100-0x014F) by 7-bit index.
// The checksum byte is not stored here; the parent muxes it in.
module cart_header_rom
   import cart_pkg::*;
(
   input  logic [6:0] index,
   input  logic       fault_inject,
   output logic [7:0] data
);

   localparam logic [6:0] TITLE_IDX     = 7'(TITLE_BASE - HEADER_BASE);
   localparam logic [6:0] TITLE_END_IDX = TITLE_IDX + 7'(TITLE_LEN);
   localparam logic [6:0] CART_IDX      = 7'(CART_TYPE_ADDR - HEADER_BASE);
   localparam logic [6:0] ROM_IDX       = 7'(ROM_SIZE_ADDR - HEADER_BASE);
   localparam logic [6:0] RAM_IDX       = 7'(RAM_SIZE_ADDR - HEADER_BASE);
   localparam logic [6:0] LIC_IDX       = 7'(LICENSEE_ADDR - HEADER_BASE);
   localparam logic [6:0] FAULT_IDX     = 7'(FAULT_ADDR - HEADER_BASE);

   always_comb begin
      data = 8'h00;
      if (index >= TITLE_IDX && index < TITLE_END_IDX) begin
         data = title_byte(4'(index - TITLE_IDX));
      end
      case (index)
         CART_IDX: data = CART_TYPE_CAMERA;
         ROM_IDX:  data = ROM_SIZE_VALUE;
         RAM_IDX:  data = RAM_SIZE_VALUE;
         LIC_IDX:  data = LICENSEE_VALUE;
         default:  ;
      endcase
      if (fault_inject && index == FAULT_IDX) begin
         data = 8'h00;
      end
   end

endmodule

// File: rtl/cart_bus_responder.sv
// Stand-in cartridge for the cart read bus: computes the header checksum
// after reset, then answers level-style reads after a fixed latency.
module cart_bus_responder
   import cart_pkg::*;
#(
   parameter int         READ_LATENCY = 4,
   parameter logic [7:0] OPEN_BUS     = 8'hFF
) (
   input  logic        clk_6_7,
   input  logic        reset_n,
   input  logic        cart_rd,
   input  logic [15:0] cart_addr,
   input  logic        fault_inject,
   output logic [7:0]  cart_data,
   output logic        data_valid,
   output logic        ready
);

   localparam logic [2:0] LAT_LOAD   = 3'(READ_LATENCY - 1);
   localparam logic [4:0] INIT_DONE  = 5'(CSUM_COUNT);
   localparam logic [6:0] CSUM_START = 7'(CSUM_FIRST - HEADER_BASE);

   cart_state_t state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        ready_q, ready_d;
   logic [7:0]  csum_q, csum_d;
   logic [4:0]  idx_q, idx_d;

   logic        addr_in_header;
   logic [6:0]  read_index;
   logic [7:0]  read_rom_byte;
   logic [7:0]  lookup_byte;
   logic [6:0]  init_index;
   logic [7:0]  init_byte;

   // Range check on the full 16-bit address before narrowing to an index.
   assign addr_in_header = (addr_q >= HEADER_BASE) && (addr_q <= HEADER_LAST);
   assign read_index     = addr_in_header ? 7'(addr_q - HEADER_BASE) : 7'd0;
   assign init_index     = CSUM_START + 7'(idx_q);

   cart_header_rom read_rom (
      .index        (read_index),
      .fault_inject (fault_inject),
      .data         (read_rom_byte)
   );

   // The checksum always covers the clean image, whatever fault_inject does.
   cart_header_rom init_rom (
      .index        (init_index),
      .fault_inject (1'b0),
      .data         (init_byte)
   );

   always_comb begin
      lookup_byte = read_rom_byte;
      if (!addr_in_header) begin
         lookup_byte = OPEN_BUS;
      end else if (addr_q == CSUM_ADDR) begin
         lookup_byte = csum_q;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      valid_d = valid_q;
      ready_d = ready_q;
      csum_d  = csum_q;
      idx_d   = idx_q;

      case (state_q)
         INIT: begin
            data_d  = OPEN_BUS;
            valid_d = 1'b0;
            if (idx_q == INIT_DONE) begin
               ready_d = 1'b1;
               state_d = IDLE;
            end else begin
               csum_d = csum_q - init_byte - 8'd1;
               idx_d  = idx_q + 5'd1;
            end
         end

         IDLE: begin
            data_d  = OPEN_BUS;
            valid_d = 1'b0;
            if (cart_rd) begin
               addr_d  = cart_addr;
               cnt_d   = LAT_LOAD;
               state_d = WAIT;
            end
         end

         WAIT, VALID: begin
            // A falling cart_rd takes priority over an address change.
            if (!cart_rd) begin
               data_d  = OPEN_BUS;
               valid_d = 1'b0;
               state_d = IDLE;
            end else if (cart_addr != addr_q) begin
               data_d  = OPEN_BUS;
               valid_d = 1'b0;
               addr_d  = cart_addr;
               cnt_d   = LAT_LOAD;
               state_d = WAIT;
            end else if (state_q == WAIT) begin
               if (cnt_q == 3'd0) begin
                  data_d  = lookup_byte;
                  valid_d = 1'b1;
                  state_d = VALID;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
         end

         default: begin
            state_d = INIT;
         end
      endcase
   end

   always_ff @(posedge clk_6_7) begin
      if (!reset_n) begin
         state_q <= INIT;
         addr_q  <= 16'h0000;
         cnt_q   <= 3'd0;
         data_q  <= OPEN_BUS;
         valid_q <= 1'b0;
         ready_q <= 1'b0;
         csum_q  <= 8'h00;
         idx_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
         csum_q  <= csum_d;
         idx_q   <= idx_d;
      end
   end

   assign cart_data  = data_q;
   assign data_valid = valid_q;
   assign ready      = ready_q;

endmodule

// File: tb/tb_cart_bus_responder.sv
// Self-checking bench for cart_bus_responder: directed scenarios plus a
// randomized phase, all compared against a behavioural cartridge model.
module tb_cart_bus_responder;

   localparam int         LAT  = 4;
   localparam logic [7:0] OPEN = 8'hFF;

   logic        clk_6_7 = 1'b0;
   logic        reset_n;
   logic        cart_rd;
   logic [15:0] cart_addr;
   logic        fault_inject;
   logic [7:0]  cart_data;
   logic        data_valid;
   logic        ready;

   int checks   = 0;
   int failures = 0;
   logic chk_en = 1'b0;

   cart_bus_responder #(.READ_LATENCY(LAT), .OPEN_BUS(OPEN)) dut (
      .clk_6_7      (clk_6_7),
      .reset_n      (reset_n),
      .cart_rd      (cart_rd),
      .cart_addr    (cart_addr),
      .fault_inject (fault_inject),
      .cart_data    (cart_data),
      .data_valid   (data_valid),
      .ready        (ready)
   );

   always #5 clk_6_7 = ~clk_6_7;

   // Reference header image and checksum, built from the header layout.
   logic [7:0] hdr [0:79];
   logic [7:0] csum_ref;
   string      title = "GAMEBOYCAMERA";
   int         init_cycles;

   function automatic logic [7:0] ref_byte(input logic [15:0] a, input logic f);
      if (a < 16'h0100 || a > 16'h014F) return OPEN;
      if (a == 16'h014D) return csum_ref;
      if (f && a == 16'h013A) return 8'h00;
      return hdr[int'(a) - 256];
   endfunction

   task automatic buildModel();
      for (int i = 0; i < 80; i++) hdr[i] = 8'h00;
      for (int i = 0; i < 13; i++) hdr[16'h34 + i] = title[i];
      hdr[16'h47] = 8'hFC;
      hdr[16'h48] = 8'h05;
      hdr[16'h49] = 8'h04;
      hdr[16'h4B] = 8'h01;
      csum_ref = 8'h00;
      for (int i = 16'h34; i <= 16'h4C; i++) csum_ref = csum_ref - hdr[i] - 8'd1;
      init_cycles = (16'h4C - 16'h34 + 1) + 1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] actual,
                              input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Cycle model: a read becomes valid LAT edges after the edge that accepted it.
   logic        m_ready  = 1'b0;
   int          m_init   = 0;
   logic        m_active = 1'b0;
   logic [15:0] m_addr   = 16'h0000;
   int          m_age    = 0;
   logic        m_valid  = 1'b0;
   logic [7:0]  m_data   = OPEN;

   always @(posedge clk_6_7) begin
      if (!reset_n) begin
         m_ready  = 1'b0;
         m_init   = 0;
         m_active = 1'b0;
         m_valid  = 1'b0;
         m_data   = OPEN;
      end else if (!m_ready) begin
         m_init++;
         if (m_init == init_cycles) m_ready = 1'b1;
      end else if (!m_active) begin
         if (cart_rd) begin
            m_active = 1'b1;
            m_addr   = cart_addr;
            m_age    = 0;
         end
      end else if (!cart_rd) begin
         m_active = 1'b0;
         m_valid  = 1'b0;
         m_data   = OPEN;
      end else if (cart_addr != m_addr) begin
         m_addr  = cart_addr;
         m_age   = 0;
         m_valid = 1'b0;
         m_data  = OPEN;
      end else if (!m_valid) begin
         m_age++;
         if (m_age == LAT) begin
            m_valid = 1'b1;
            m_data  = ref_byte(m_addr, fault_inject);
         end
      end
   end

   always @(negedge clk_6_7) begin
      if (chk_en) begin
         checkOutput("cyc_data", 16'(cart_data), 16'(m_data));
         checkOutput("cyc_valid", 16'(data_valid), 16'(m_valid));
         checkOutput("cyc_ready", 16'(ready), 16'(m_ready));
      end
   end

   task automatic applyStimulus(input logic rd, input logic [15:0] a,
                                input logic f, input int cycles);
      cart_rd      = rd;
      cart_addr    = a;
      fault_inject = f;
      repeat (cycles) @(negedge clk_6_7);
   endtask

   task automatic waitReady(output int n);
      n = 0;
      do begin
         @(negedge clk_6_7);
         n++;
      end while (!ready && n < 60);
   endtask

   task automatic waitValid(output int n);
      n = 0;
      do begin
         @(negedge clk_6_7);
         n++;
      end while (!data_valid && n < 20);
   endtask

   task automatic readSweep(input logic f);
      for (int i = 0; i < 13; i++) begin
         applyStimulus(1'b1, 16'h0134 + 16'(i), f, 8);
         checkOutput("sweep_char", 16'(cart_data),
                     (f && i == 6) ? 16'h0000 : 16'(title[i]));
      end
      applyStimulus(1'b1, 16'h014D, f, 8);
      checkOutput("sweep_csum", 16'(cart_data), 16'h0034);
      applyStimulus(1'b0, 16'h0000, 1'b0, 2);
   endtask

   initial begin
      int n;
      int low;
      buildModel();
      reset_n      = 1'b0;
      cart_rd      = 1'b0;
      cart_addr    = 16'h0000;
      fault_inject = 1'b0;
      @(negedge clk_6_7);
      chk_en = 1'b1;
      checkOutput("reset_ready", 16'(ready), 16'h0000);
      checkOutput("reset_data", 16'(cart_data), 16'h00FF);
      repeat (2) @(negedge clk_6_7);

      reset_n = 1'b1;
      waitReady(n);
      checkOutput("ready_cycles", 16'(n), 16'd26);
      checkOutput("model_csum", 16'(csum_ref), 16'h0034);
      applyStimulus(1'b1, 16'h014D, 1'b0, 8);
      checkOutput("csum_read", 16'(cart_data), 16'h0034);
      applyStimulus(1'b0, 16'h0000, 1'b0, 2);

      cart_rd   = 1'b1;
      cart_addr = 16'h0134;
      waitValid(n);
      checkOutput("latency", 16'(n - 1), 16'(LAT));
      checkOutput("first_byte", 16'(cart_data), 16'h0047);
      applyStimulus(1'b1, 16'h0134, 1'b0, 5);
      checkOutput("hold_valid", 16'(data_valid), 16'h0001);
      checkOutput("hold_data", 16'(cart_data), 16'h0047);
      applyStimulus(1'b0, 16'h0000, 1'b0, 2);

      readSweep(1'b0);
      readSweep(1'b1);

      applyStimulus(1'b1, 16'h0147, 1'b0, 7);
      checkOutput("cart_type", 16'(cart_data), 16'h00FC);
      cart_addr = 16'h0148;
      low = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk_6_7);
         if (data_valid) break;
         low++;
      end
      checkOutput("change_low", 16'(low), 16'(LAT));
      checkOutput("rom_size", 16'(cart_data), 16'h0005);
      applyStimulus(1'b1, 16'h8000, 1'b0, 7);
      checkOutput("open_valid", 16'(data_valid), 16'h0001);
      checkOutput("open_data", 16'(cart_data), 16'h00FF);
      applyStimulus(1'b0, 16'h0000, 1'b0, 2);

      // Read held high through reset release: accepted on the first IDLE edge.
      reset_n = 1'b0;
      applyStimulus(1'b1, 16'h0134, 1'b0, 2);
      reset_n = 1'b1;
      waitReady(n);
      checkOutput("held_ready", 16'(n), 16'd26);
      waitValid(n);
      checkOutput("held_latency", 16'(n), 16'(LAT + 1));
      checkOutput("held_data", 16'(cart_data), 16'h0047);
      applyStimulus(1'b0, 16'h0000, 1'b0, 2);

      applyStimulus(1'b1, 16'h0149, 1'b0, 2);
      checkOutput("wait_state", 16'(data_valid), 16'h0000);
      reset_n = 1'b0;
      @(negedge clk_6_7);
      checkOutput("abort_valid", 16'(data_valid), 16'h0000);
      checkOutput("abort_data", 16'(cart_data), 16'h00FF);
      checkOutput("abort_ready", 16'(ready), 16'h0000);
      cart_rd = 1'b0;
      reset_n = 1'b1;
      waitReady(n);
      checkOutput("rerun_ready", 16'(n), 16'd26);
      applyStimulus(1'b1, 16'h014D, 1'b0, 8);
      checkOutput("rerun_csum", 16'(cart_data), 16'h0034);
      applyStimulus(1'b0, 16'h0000, 1'b0, 2);

      for (int it = 0; it < 300; it++) begin
         logic [15:0] a;
         int sel;
         if ($urandom_range(0, 99) < 2) begin
            reset_n = 1'b0;
            @(negedge clk_6_7);
            reset_n = 1'b1;
         end
         if ($urandom_range(0, 2) == 0) begin
            applyStimulus(cart_rd, cart_addr, 1'($urandom_range(0, 1)),
                          $urandom_range(1, 6));
         end else begin
            sel = $urandom_range(0, 3);
            case (sel)
               0:       a = 16'h0100 + 16'($urandom_range(0, 79));
               1:       a = 16'h0134 + 16'($urandom_range(0, 12));
               2:       a = 16'h014D;
               default: a = 16'($urandom);
            endcase
            applyStimulus($urandom_range(0, 3) != 0, a, 1'($urandom_range(0, 1)),
                          $urandom_range(1, 8));
         end
      end

      applyStimulus(1'b0, 16'h0000, 1'b0, 3);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
